// File: rtl/mfu_add_sched.sv
// Round-robin scheduler sharing one MFU element-wise vector adder between two requesters.
// Latches operands, holds the adder enabled until it completes or the watchdog expires, then returns a tagged result.
module mfu_add_sched #(
    parameter int DESIGN_SIZE = 10,
    parameter int DWIDTH      = 16,
    parameter int ADD_LATENCY = 4,
    parameter int TIMEOUT     = ADD_LATENCY + 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic [2*DESIGN_SIZE*DWIDTH-1:0] req_a,
    input  logic [2*DESIGN_SIZE*DWIDTH-1:0] req_b,
    output logic                            add_enable,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   add_primary,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   add_secondary,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   add_result,
    input  logic                            add_done,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_id,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   resp_data,
    output logic                            busy,
    output logic                            err_timeout
);
    localparam int VW = DESIGN_SIZE * DWIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_reg, state_next;
    logic [VW-1:0] port_a [2];
    logic [VW-1:0] port_b [2];
    logic [VW-1:0] op_a_reg, op_b_reg, resp_data_reg;
    logic          owner_reg, last_grant_reg, resp_id_reg, err_reg;
    logic [CW-1:0] wd_reg;
    logic          grant_any, grant_id, wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_a[gi] = req_a[gi*VW +: VW];
            assign port_b[gi] = req_b[gi*VW +: VW];
        end
    endgenerate

    // Gated by resetn so req_ready reads 0 while reset is held, even with requests pending.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (resetn && state_reg == IDLE && req_valid != 2'b00) begin
            grant_any = 1'b1;
            case (req_valid)
                2'b01:   grant_id = 1'b0;
                2'b10:   grant_id = 1'b1;
                default: grant_id = ~last_grant_reg;
            endcase
        end
    end

    assign req_ready  = {grant_any & grant_id, grant_any & ~grant_id};
    assign wd_expired = (wd_reg == WD_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   if (add_done || wd_expired) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            wd_reg         <= '0;
            resp_data_reg  <= '0;
            resp_id_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        op_a_reg       <= port_a[grant_id];
                        op_b_reg       <= port_b[grant_id];
                        owner_reg      <= grant_id;
                        last_grant_reg <= grant_id;
                        wd_reg         <= '0;
                    end
                end
                ISSUE: begin
                    wd_reg <= wd_reg + 1'b1;
                    // A completion arriving on the last watchdog cycle still wins.
                    if (add_done) begin
                        resp_data_reg <= add_result;
                        resp_id_reg   <= owner_reg;
                    end else if (wd_expired) begin
                        resp_data_reg <= '0;
                        resp_id_reg   <= owner_reg;
                        err_reg       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_enable    = (state_reg == ISSUE);
    assign add_primary   = op_a_reg;
    assign add_secondary = op_b_reg;
    assign resp_valid    = (state_reg == RESP);
    assign resp_id       = resp_id_reg;
    assign resp_data     = resp_data_reg;
    assign busy          = (state_reg != IDLE);
    assign err_timeout   = err_reg;
endmodule

// File: doc/mfu_add_sched.md
# mfu_add_sched

Round-robin scheduler that shares one element-wise vector adder in the MFU between two requesters (port 0: MVU result path, port 1: instruction/host path). Each accepted request is one DESIGN_SIZE-lane vector op. The scheduler latches the operands, drives the adder's enable/operand inputs until the adder reports completion, then returns the result tagged with the requester ID. A watchdog flags an adder that never completes.

## Interface
- DESIGN_SIZE, 10, lanes per vector
- DWIDTH, 16, bits per lane
- ADD_LATENCY, 4, adder latency in enabled cycles; completion is expected ADD_LATENCY+1 cycles after enable rises
- TIMEOUT, ADD_LATENCY+8, max cycles in ISSUE before error
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept, one-hot or zero
- req_a  in  2*DESIGN_SIZE*DWIDTH  primary operands, port i at slice i
- req_b  in  2*DESIGN_SIZE*DWIDTH  secondary operands, port i at slice i
- add_enable  out  1  adder enable
- add_primary  out  DESIGN_SIZE*DWIDTH  adder primary input
- add_secondary  out  DESIGN_SIZE*DWIDTH  adder secondary input
- add_result  in  DESIGN_SIZE*DWIDTH  adder output
- add_done  in  1  adder output-available
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accept
- resp_id  out  1  requester that owns resp_data
- resp_data  out  DESIGN_SIZE*DWIDTH  captured result
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky watchdog error

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any req_valid, grant one. The granted port's req_ready is 1 combinationally in this cycle. Latch its req_a/req_b into operand registers and its index into the owner register, then go to ISSUE.
- Arbitration: if only one port is valid, grant it. If both are valid, grant the port != last_grant. last_grant updates on each grant. Reset value of last_grant is 1, so port 0 wins the first tie.
- req_ready is 0 in ISSUE and RESP. Requests wait; they are never dropped.
- ISSUE: add_enable=1, and add_primary/add_secondary are driven from the operand registers, stable for the whole state. The watchdog counter increments each cycle.
  - add_done=1: capture add_result into resp_data, resp_id=owner, go to RESP.
  - Counter reaches TIMEOUT-1 with no add_done: set err_timeout, load resp_data with zero, go to RESP. The requester still gets a response.
- RESP: add_enable=0, which forces the adder to reset its internal count. resp_valid=1 and resp_data/resp_id are held stable.
  - resp_ready=1: go to IDLE.
- add_done while not in ISSUE is ignored.
- err_timeout is cleared only by reset.
- Data lanes pass through unmodified. The scheduler does no arithmetic on the payload.
- Reset (asynchronous, mid-operation included):
  - State IDLE; all outputs 0 (add_enable, add_primary, add_secondary, resp_valid, resp_id, resp_data, busy, err_timeout, req_ready).
  - Watchdog counter 0; last_grant 1.
  - Any in-flight op is abandoned with no response.

## Timing
- Cycle 0: grant (req_valid & req_ready).
- Cycle 1: add_enable rises.
- add_done is seen at cycle 1+ADD_LATENCY+1 for the nominal adder. resp_valid rises the following cycle.
- Minimum accept-to-resp_valid latency: ADD_LATENCY+3 cycles.
- add_enable is low for at least one cycle between consecutive ops (RESP, then IDLE).
- Back-to-back throughput: one op per ADD_LATENCY+4 cycles when resp_ready is held at 1 (grant, ISSUE, RESP, with the next grant in IDLE).
- Response stall: resp_valid stays asserted and RESP is held indefinitely. No new grant occurs while stalled.
- Watchdog counter width is clog2(TIMEOUT+1). It is cleared on entry to ISSUE.

## Test plan
- Single request, port 0, lanes a=0x0001..0x000A, b=0x0100; bench adder model with lane sum and ADD_LATENCY=4 -> req_ready[0] for one cycle; add_enable high 6 cycles; resp_valid 7 cycles after grant with lanes 0x0101..0x010A and resp_id=0.
- Both ports valid continuously, resp_ready=1 -> grants alternate 0,1,0,1. Four responses arrive in order with resp_id 0,1,0,1, each 8 cycles apart.
- resp_ready held 0 for 20 cycles after resp_valid -> resp_data/resp_id are stable; req_ready stays 0 despite pending requests; the next grant comes one cycle after resp_ready=1.
- Adder model never asserts add_done -> at the TIMEOUT-th ISSUE cycle, err_timeout=1 and sticky; resp_valid arrives with resp_data=0; the scheduler then serves the next request normally.
- resetn pulsed low mid-ISSUE (asynchronously, between edges) -> all outputs go to 0 immediately. After release, a tie is granted to port 0.
- Spurious add_done pulse while in IDLE, then a request -> the pulse is ignored, and the result is the one captured during ISSUE.
